// File: rtl/bus_hub_pkg.sv
// Shared types and constants for the N-port pipelined bus hub.
package bus_hub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // No device selected: all-ones, truncated to the select width at the use site.
    // The select width always leaves this code above the largest device index.
    localparam logic [31:0] SEL_NONE = '1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Widest device_active vector the multihit check accepts.
    localparam int unsigned MAX_DEV = 64;

    // Number of set bits in a device_active vector.
    function automatic int unsigned onehot_count(input logic [MAX_DEV-1:0] v);
        onehot_count = 0;
        for (int i = 0; i < int'(MAX_DEV); i++) begin
            if (v[i]) onehot_count++;
        end
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Highest-set-bit priority encoder with a valid flag.
module bus_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Later iterations override earlier ones, so the highest set index wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_hub_n_pl.sv
// N-port pipelined bus hub: one host to N_DEV self-decoding devices, with
// stall timeout and error completion for unmapped/timed-out accesses.
// Optional macro BUS_HUB_MULTIHIT_ERR_EN: multi-hit requests complete with an error.
module bus_hub_n_pl
    import bus_hub_pkg::*;
#(
    parameter int unsigned       N_DEV          = 4,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          host_address,
    input  logic [DATA_W-1:0]          host_data_write,
    input  logic [DATA_W/8-1:0]        host_write_mask,
    input  logic                       host_ren,
    input  logic                       host_wen,
    output logic [DATA_W-1:0]          host_data_read,
    output logic                       host_ready,
    output logic                       host_error,
    output logic [N_DEV*ADDR_W-1:0]    device_address,
    output logic [N_DEV*DATA_W-1:0]    device_data_write,
    output logic [N_DEV*DATA_W/8-1:0]  device_write_mask,
    output logic [N_DEV-1:0]           device_ren,
    output logic [N_DEV-1:0]           device_wen,
    input  logic [N_DEV-1:0]           device_ready,
    input  logic [N_DEV*DATA_W-1:0]    device_data_read,
    input  logic [N_DEV-1:0]           device_active
);

    localparam int unsigned SEL_W = $clog2(N_DEV + 1);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SEL_W-1:0] SEL_NONE_W = SEL_W'(SEL_NONE);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] resp_sel_q, resp_sel_d;
    logic [SEL_W-1:0] sel_now;
    logic [SEL_W-1:0] strobe_idx;
    logic             strobe_en;
    logic             hit_valid;
    logic             multihit;
    logic             rdy_now;
    logic             rdy_held;
    logic             req;
    logic [DATA_W-1:0] rd_data;

    assign req = host_ren | host_wen;

    assign device_address    = {N_DEV{host_address}};
    assign device_data_write = {N_DEV{host_data_write}};
    assign device_write_mask = {N_DEV{host_write_mask}};

    bus_prio_enc #(
        .N     (N_DEV),
        .IDX_W (SEL_W)
    ) u_prio_enc (
        .req   (device_active),
        .idx   (sel_now),
        .valid (hit_valid)
    );

`ifdef BUS_HUB_MULTIHIT_ERR_EN
    assign multihit = onehot_count(MAX_DEV'(device_active)) > 1;
`else
    assign multihit = 1'b0;
`endif

    // Ready and read-data muxes; an index of SEL_NONE matches no device.
    always_comb begin
        rdy_now  = 1'b0;
        rdy_held = 1'b0;
        rd_data  = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (sel_now == SEL_W'(i))    rdy_now  = device_ready[i];
            if (sel_q == SEL_W'(i))      rdy_held = device_ready[i];
            if (resp_sel_q == SEL_W'(i)) rd_data  = device_data_read[i*DATA_W +: DATA_W];
        end
    end

    assign host_data_read = (state_q == ERR) ? ERR_DATA : rd_data;

    // State, stall counter and select registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            resp_sel_q <= SEL_NONE_W;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            resp_sel_q <= resp_sel_d;
        end
    end

    // Next-state, handshake and strobe selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        strobe_en  = 1'b0;
        strobe_idx = sel_q;
        host_ready = 1'b1;
        host_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!hit_valid || multihit) begin
                        host_ready = 1'b0;
                        state_d    = ERR;
                    end else begin
                        strobe_en  = 1'b1;
                        strobe_idx = sel_now;
                        host_ready = rdy_now;
                        if (!rdy_now) begin
                            sel_d   = sel_now;
                            cnt_d   = CNT_W'(1);
                            state_d = (TIMEOUT_CYCLES == 1) ? ERR : WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    strobe_en  = 1'b1;
                    host_ready = rdy_held;
                    if (rdy_held) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q >= CNT_LAST) begin
                        // cnt_q stalled cycles so far plus this one reach the limit.
                        state_d = ERR;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                host_error = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_sel_d = strobe_en ? strobe_idx : SEL_NONE_W;
    end

    // Per-device strobes follow the host strobes only for the selected device.
    always_comb begin
        device_ren = '0;
        device_wen = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (strobe_en && strobe_idx == SEL_W'(i)) begin
                device_ren[i] = host_ren;
                device_wen[i] = host_wen;
            end
        end
    end

endmodule

// File: tb/tb_bus_hub_n_pl.sv
// Randomised transaction-level bench for bus_hub_n_pl.
module tb_bus_hub_n_pl;

    localparam int unsigned N_DEV   = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEADBEEF;
`ifdef BUS_HUB_MULTIHIT_ERR_EN
    localparam bit MULTI_ERR = 1'b1;
`else
    localparam bit MULTI_ERR = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [ADDR_W-1:0]         host_address;
    logic [DATA_W-1:0]         host_data_write;
    logic [DATA_W/8-1:0]       host_write_mask;
    logic                      host_ren;
    logic                      host_wen;
    logic [DATA_W-1:0]         host_data_read;
    logic                      host_ready;
    logic                      host_error;
    logic [N_DEV*ADDR_W-1:0]   device_address;
    logic [N_DEV*DATA_W-1:0]   device_data_write;
    logic [N_DEV*DATA_W/8-1:0] device_write_mask;
    logic [N_DEV-1:0]          device_ren;
    logic [N_DEV-1:0]          device_wen;
    logic [N_DEV-1:0]          device_ready;
    logic [N_DEV*DATA_W-1:0]   device_data_read;
    logic [N_DEV-1:0]          device_active;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [DATA_W-1:0] dev_data [N_DEV];

    bus_hub_n_pl #(
        .N_DEV          (N_DEV),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_DATA       (ERR_WORD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .host_address      (host_address),
        .host_data_write   (host_data_write),
        .host_write_mask   (host_write_mask),
        .host_ren          (host_ren),
        .host_wen          (host_wen),
        .host_data_read    (host_data_read),
        .host_ready        (host_ready),
        .host_error        (host_error),
        .device_address    (device_address),
        .device_data_write (device_data_write),
        .device_write_mask (device_write_mask),
        .device_ren        (device_ren),
        .device_wen        (device_wen),
        .device_ready      (device_ready),
        .device_data_read  (device_data_read),
        .device_active     (device_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_dev_data();
        for (int i = 0; i < int'(N_DEV); i++)
            device_data_read[i*DATA_W +: DATA_W] = dev_data[i];
    endtask

    task automatic check_outputs(input string ph, input logic rdy, input logic err,
                                 input logic [N_DEV-1:0] ren, input logic [N_DEV-1:0] wen,
                                 input logic [DATA_W-1:0] data);
        check({ph, " ready"}, 64'(host_ready), 64'(rdy));
        check({ph, " error"}, 64'(host_error), 64'(err));
        check({ph, " ren"},   64'(device_ren), 64'(ren));
        check({ph, " wen"},   64'(device_wen), 64'(wen));
        check({ph, " rdata"}, 64'(host_data_read), 64'(data));
    endtask

    // One host transaction: the winning device answers after lat cycles.
    // The model decides the outcome from the first-cycle decode alone.
    task automatic run_txn(input logic is_wr, input logic [N_DEV-1:0] act, input int lat,
                           input bit fixed_data, input logic [DATA_W-1:0] fdata);
        int  hits = 0;
        int  t = 0;
        bit  unmapped;
        bit  done = 0;
        bit  ok = 0;
        logic [N_DEV-1:0] oh;
        logic [N_DEV-1:0] eren, ewen;
        for (int i = 0; i < int'(N_DEV); i++) begin
            dev_data[i] = $urandom;
            if (act[i]) begin hits++; t = i; end
        end
        if (fixed_data) dev_data[t] = fdata;
        load_dev_data();
        unmapped = (hits == 0) || (MULTI_ERR && hits > 1);
        oh = N_DEV'(1) << t;
        host_address    = $urandom;
        host_data_write = $urandom;
        host_write_mask = 4'($urandom);
        host_ren = !is_wr;
        host_wen = is_wr;
        for (int k = 0; !done && k <= int'(TIMEOUT); k++) begin
            device_active = (k == 0) ? act : N_DEV'($urandom);
            device_ready  = N_DEV'($urandom);
            if (!unmapped) device_ready[t] = (k >= lat);
            @(negedge clk);
            eren = (!unmapped && !is_wr) ? oh : '0;
            ewen = (!unmapped && is_wr) ? oh : '0;
            if (unmapped) begin
                if (k == 0) check_outputs("unmapped stall", 1'b0, 1'b0, '0, '0, '0);
                else begin
                    check_outputs("unmapped err", 1'b1, 1'b1, '0, '0, ERR_WORD);
                    done = 1;
                end
            end else if (k < int'(TIMEOUT)) begin
                check_outputs(k < lat ? "stall" : "complete", k >= lat, 1'b0, eren, ewen,
                              (k == 0) ? '0 : dev_data[t]);
                if (k >= lat) begin done = 1; ok = 1; end
            end else begin
                check_outputs("timeout err", 1'b1, 1'b1, '0, '0, ERR_WORD);
                done = 1;
            end
            check("addr bcast", 64'(device_address[(N_DEV-1)*ADDR_W +: ADDR_W]), 64'(host_address));
            @(posedge clk); #1;
        end
        if (!done) check("txn bound", 64'(done), 64'(1));
        // Idle cycle: registered read-data select shows the completed device or zero.
        host_ren = 1'b0;
        host_wen = 1'b0;
        device_active = N_DEV'($urandom);
        device_ready  = N_DEV'($urandom);
        @(negedge clk);
        check_outputs("idle after", 1'b1, 1'b0, '0, '0, ok ? dev_data[t] : '0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        host_address = '0; host_data_write = '0; host_write_mask = '0;
        host_ren = 1'b0; host_wen = 1'b0;
        device_ready = '0; device_active = '0; device_data_read = '0;
        for (int i = 0; i < int'(N_DEV); i++) dev_data[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset", 1'b1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;

        run_txn(1'b0, 4'b0100, 0, 1'b1, 32'h12345678);     // zero-wait read
        run_txn(1'b0, 4'b0010, 3, 1'b0, '0);               // three wait states
        run_txn(1'b0, 4'b1000, 1000, 1'b0, '0);            // timeout
        run_txn(1'b1, 4'b0000, 0, 1'b0, '0);               // unmapped write
        run_txn(1'b0, 4'b0011, 0, 1'b0, '0);               // multi-hit
        run_txn(1'b1, 4'b0001, int'(TIMEOUT) - 1, 1'b0, '0); // last cycle before timeout

        // Reset in the middle of a stall abandons the access.
        for (int i = 0; i < int'(N_DEV); i++) dev_data[i] = $urandom;
        load_dev_data();
        host_ren = 1'b1;
        device_active = 4'b0100;
        device_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        host_ren = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset mid-wait", 1'b1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            logic [N_DEV-1:0] act;
            act = ($urandom_range(0, 7) == 0) ? '0 : N_DEV'($urandom);
            run_txn(1'($urandom), act, int'($urandom_range(0, 10)), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
